// File: rtl/key_pkg.sv
// Shared types and width helpers for the multi-key press classifier.
package key_pkg;

    // Per-channel classifier state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } key_state_t;

    // Bits needed to hold the values 0..max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    // Counter widths for the default timing (50 MHz board clock).
    localparam int unsigned DEF_DB_W   = cnt_width(255);
    localparam int unsigned DEF_HOLD_W = cnt_width(25000000);
    localparam int unsigned DEF_REP_W  = cnt_width(5000000);

endpackage

// File: rtl/key_channel.sv
// One button channel: 2-FF synchroniser, debounce filter and
// short / long / auto-repeat press classifier.
module key_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = 255,
    parameter int unsigned LONG_CNT     = 25000000,
    parameter int unsigned REPEAT_EN    = 1,
    parameter int unsigned REPEAT_CNT   = 5000000,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic key_held,
    output logic key_press_short,
    output logic key_press_long,
    output logic key_repeat
);

    localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CNT);
    localparam int unsigned HOLD_W = cnt_width(LONG_CNT);
    localparam int unsigned REP_W  = cnt_width(REPEAT_CNT);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [DB_W-1:0]   DB_SAT    = DB_W'(DEBOUNCE_CNT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CNT);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CNT - 1);
    localparam logic [REP_W-1:0]  REP_SAT   = REP_W'(REPEAT_CNT);

    // Level the raw input shows while the button is released.
    localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic              sync1;
    logic              sync2;
    logic              p;
    logic              db;
    logic [DB_W-1:0]   db_cnt;
    logic              db_toggle;
    logic              db_rise;
    logic              db_fall;

    key_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic              short_q;
    logic              long_q;
    logic              rep_q;

    // Two-flop synchroniser, reset to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= REL_LVL;
            sync2 <= REL_LVL;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // Polarity normalisation and debounce toggle decode.
    // The classifier acts on the toggle event rather than on the new db
    // level so that it changes state on the same edge as key_held.
    always_comb begin
        p         = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
        db_toggle = (p != db) && (db_cnt == DB_LAST);
        db_rise   = db_toggle && !db;
        db_fall   = db_toggle && db;
    end

    // Debounce: accept a new level after DEBOUNCE_CNT stable samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db     <= 1'b0;
            db_cnt <= '0;
        end else if (p == db) begin
            db_cnt <= '0;
        end else if (db_toggle) begin
            db     <= ~db;
            db_cnt <= '0;
        end else if (db_cnt != DB_SAT) begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Press classifier with registered one-cycle pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            rep_q    <= 1'b0;
        end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (db_rise) begin
                        state    <= PRESSED;
                        hold_cnt <= '0;
                    end
                end
                PRESSED: begin
                    // Release takes priority over a long press due this cycle.
                    if (db_fall) begin
                        short_q <= 1'b1;
                        state   <= IDLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        long_q  <= 1'b1;
                        state   <= LONG;
                        rep_cnt <= '0;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                LONG: begin
                    // Release suppresses any repeat due this cycle.
                    if (db_fall) begin
                        state <= IDLE;
                    end else if (REPEAT_EN != 0) begin
                        if (rep_cnt == REP_LAST) begin
                            rep_q   <= 1'b1;
                            rep_cnt <= '0;
                        end else if (rep_cnt != REP_SAT) begin
                            rep_cnt <= rep_cnt + REP_W'(1);
                        end
                    end else begin
                        rep_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign key_held        = db;
    assign key_press_short = short_q;
    assign key_press_long  = long_q;
    assign key_repeat      = rep_q;

endmodule

// File: rtl/key_multi_press.sv
// N independent push-button channels, each debounced and classified
// into short press, long press and auto-repeat pulses.
module key_multi_press
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS       = 4,
    parameter int unsigned DEBOUNCE_CNT = 255,
    parameter int unsigned LONG_CNT     = 25000000,
    parameter int unsigned REPEAT_EN    = 1,
    parameter int unsigned REPEAT_CNT   = 5000000,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] button,
    output logic [N_KEYS-1:0] key_held,
    output logic [N_KEYS-1:0] key_press_short,
    output logic [N_KEYS-1:0] key_press_long,
    output logic [N_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .LONG_CNT     (LONG_CNT),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_CNT   (REPEAT_CNT),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk             (clk),
            .rst_n           (rst_n),
            .button          (button[i]),
            .key_held        (key_held[i]),
            .key_press_short (key_press_short[i]),
            .key_press_long  (key_press_long[i]),
            .key_repeat      (key_repeat[i])
        );
    end

endmodule

// File: doc/key_multi_press.md
Name: key_multi_press

Overview:
- N-channel successor to the single-key long/short detector. Each channel synchronises, debounces and classifies one push-button.
- Per channel it emits one-cycle pulses for short press, long press and optional auto-repeat while held, plus a debounced level.
- Sits between the board buttons and the clock-setting control FSM. Timing is expressed in clk cycles.

Parameters:
- N_KEYS, 4, number of independent button channels (1..16)
- DEBOUNCE_CNT, 255, consecutive stable samples required to accept a level change (>=1)
- LONG_CNT, 25000000, held cycles after debounced press at which long fires (> DEBOUNCE_CNT)
- REPEAT_EN, 1, 1 = auto-repeat pulses after long; 0 = none
- REPEAT_CNT, 5000000, cycles between repeat pulses (>=2)
- ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- button  in  N_KEYS  raw asynchronous button inputs
- key_held  out  N_KEYS  debounced pressed level
- key_press_short  out  N_KEYS  1-cycle pulse: released before LONG_CNT
- key_press_long  out  N_KEYS  1-cycle pulse: held LONG_CNT cycles
- key_repeat  out  N_KEYS  1-cycle pulse every REPEAT_CNT cycles after long

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Channels are fully independent. No arbitration between channels. Simultaneous events on several channels each pulse in the same cycle.
- Reset: all outputs 0, all counters 0, FSM in IDLE.
  - Sync flops reset to the released level (1 if ACTIVE_LOW).
  - Reset mid-press drops to IDLE with no pulses.
  - After reset release, a key still held must pass full debounce and is then treated as a new press.
- Input stage: raw input → 2-FF synchroniser → polarity normalised so that p = 1 means pressed.
- Debounce:
  - db is the debounced level.
  - db_cnt increments while p != db and clears whenever p == db.
  - When db_cnt reaches DEBOUNCE_CNT-1 with p != db, db toggles and db_cnt clears.
  - Any glitch shorter than DEBOUNCE_CNT samples is ignored.
- key_held = db, registered.
- Press latency: raw edge → key_held rise = 2 + DEBOUNCE_CNT cycles.
- Classifier FSM per channel, states IDLE, PRESSED, LONG:
  - IDLE: on db rise → PRESSED, hold_cnt = 0.
  - PRESSED, db = 1: hold_cnt++.
  - PRESSED, hold_cnt == LONG_CNT-1: key_press_long pulses next cycle; → LONG, rep_cnt = 0.
  - PRESSED, db fall: key_press_short pulses next cycle; → IDLE.
  - Boundary: if the db fall and hold_cnt == LONG_CNT-1 occur in the same cycle, release wins: short only, no long.
  - LONG, REPEAT_EN = 1: rep_cnt++. At REPEAT_CNT-1, key_repeat pulses and rep_cnt wraps to 0.
  - LONG, REPEAT_EN = 0: rep_cnt is held at 0.
  - LONG, db fall: → IDLE. No short pulse. Any repeat due in that same cycle is suppressed.
- Output rules:
  - All pulse outputs are registered and exactly one cycle wide.
  - Pulses per press: at most one short, or one long followed by zero or more repeats.
- Widths:
  - db_cnt width = $clog2(DEBOUNCE_CNT+1).
  - hold_cnt width = $clog2(LONG_CNT+1).
  - rep_cnt width = $clog2(REPEAT_CNT+1).
  - Counters saturate and never wrap, except rep_cnt, which wraps as specified above.

Decomposition:
- Package key_pkg: enum key_state_t {IDLE, PRESSED, LONG} and width helper localparams.
- Sub-module key_channel: one channel's synchroniser, debounce and FSM, with the same parameters minus N_KEYS.
- Top level is a generate loop instantiating N_KEYS × key_channel.

Test Plan:
- Parameters for all scenarios: N_KEYS=2, DEBOUNCE_CNT=4, LONG_CNT=20, REPEAT_CNT=8, ACTIVE_LOW=1.
- 1. Ch0 low for 10 cycles, then high → key_held[0] high from cycle 6. key_press_short[0] one pulse after release debounce. No long, no repeat.
- 2. Ch0 low for 3 cycles, high, repeated 5× → no key_held and no pulses on any output.
- 3. Ch1 held low 60 cycles → key_press_long[1] once, 20 cycles after key_held rise. key_repeat[1] every 8 cycles thereafter (≥3 pulses). No short on release.
- 4. REPEAT_EN=0, same stimulus as scenario 3 → exactly one long pulse, zero repeats, zero shorts.
- 5. Both channels pressed in the same cycle, ch0 10 cycles, ch1 60 cycles → independent short[0] and long[1]. Pulses can coincide without interference.
- 6. Ch0 held 15 cycles, then rst_n low for 2 cycles while still held → all outputs 0 during reset. After release: new debounce, key_held rises 6 cycles later, no stale pulses.
